// File: rtl/bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_pkg : shared FSM state, owner and grant encodings for bus_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_arbiter_if : instruction/data master buses plus the shared slave bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int XLEN = 32
);
  logic              i_cyc;
  logic              i_stb;
  logic [XLEN-1:0]   i_adr;
  logic [XLEN-1:0]   i_dat_r;
  logic              i_ack;
  logic              i_err;

  logic              d_cyc;
  logic              d_stb;
  logic              d_we;
  logic [XLEN/8-1:0] d_sel;
  logic [XLEN-1:0]   d_adr;
  logic [XLEN-1:0]   d_dat_w;
  logic [XLEN-1:0]   d_dat_r;
  logic              d_ack;
  logic              d_err;

  logic              s_cyc;
  logic              s_stb;
  logic              s_we;
  logic [XLEN/8-1:0] s_sel;
  logic [XLEN-1:0]   s_adr;
  logic [XLEN-1:0]   s_dat_w;
  logic [XLEN-1:0]   s_dat_r;
  logic              s_ack;

  // Arbiter view: requests in from both masters, shared bus out.
  modport arb (
    input  i_cyc, i_stb, i_adr,
    output i_dat_r, i_ack, i_err,
    input  d_cyc, d_stb, d_we, d_sel, d_adr, d_dat_w,
    output d_dat_r, d_ack, d_err,
    output s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_w,
    input  s_dat_r, s_ack
  );

  modport master (
    output i_cyc, i_stb, i_adr,
    input  i_dat_r, i_ack, i_err,
    output d_cyc, d_stb, d_we, d_sel, d_adr, d_dat_w,
    input  d_dat_r, d_ack, d_err
  );

  modport slave (
    input  s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_w,
    output s_dat_r, s_ack
  );

endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_arbiter : round-robin Wishbone-classic arbiter, instr + data masters
// Rev 1.0
// ---------------------------------------------------------------------------
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  bus_arbiter_if.arb      bus,
  output logic [1:0]      grant
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  owner_t            last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic req_i;
  logic req_d;
  logic timeout;

  assign req_i   = bus.i_cyc & bus.i_stb;
  assign req_d   = bus.d_cyc & bus.d_stb;
  assign timeout = (cnt_q == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= OWNER_I;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    grant       = GRANT_NONE;
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_sel   = '0;
    bus.s_adr   = '0;
    bus.s_dat_w = '0;
    bus.i_dat_r = '0;
    bus.i_ack   = 1'b0;
    bus.i_err   = 1'b0;
    bus.d_dat_r = '0;
    bus.d_ack   = 1'b0;
    bus.d_err   = 1'b0;

    // While reset is held every output stays quiet, even mid-transfer.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (req_i && req_d) begin
            state_d = (last_q == OWNER_I) ? GNT_D : GNT_I;
          end else if (req_d) begin
            state_d = GNT_D;
          end else if (req_i) begin
            state_d = GNT_I;
          end
        end

        GNT_I: begin
          grant       = GRANT_I;
          bus.s_cyc   = bus.i_cyc;
          bus.s_stb   = bus.i_stb;
          bus.s_sel   = '1;
          bus.s_adr   = bus.i_adr;
          bus.i_ack   = bus.s_ack;
          bus.i_dat_r = bus.s_dat_r;
          if (!bus.i_cyc || bus.s_ack) begin
            state_d = IDLE;
            last_d  = OWNER_I;
          end else if (timeout) begin
            bus.i_err = 1'b1;
            state_d   = IDLE;
            last_d    = OWNER_I;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        GNT_D: begin
          grant       = GRANT_D;
          bus.s_cyc   = bus.d_cyc;
          bus.s_stb   = bus.d_stb;
          bus.s_we    = bus.d_we;
          bus.s_sel   = bus.d_sel;
          bus.s_adr   = bus.d_adr;
          bus.s_dat_w = bus.d_dat_w;
          bus.d_ack   = bus.s_ack;
          bus.d_dat_r = bus.s_dat_r;
          if (!bus.d_cyc || bus.s_ack) begin
            state_d = IDLE;
            last_d  = OWNER_D;
          end else if (timeout) begin
            bus.d_err = 1'b1;
            state_d   = IDLE;
            last_d    = OWNER_D;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bus_arbiter : directed self-checking bench for bus_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  int         vectors     = 0;
  int         miscompares = 0;

  bus_arbiter_if #(.XLEN(XLEN)) bus ();

  bus_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .grant (grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.i_cyc   = 1'b0;
    bus.i_stb   = 1'b0;
    bus.i_adr   = '0;
    bus.d_cyc   = 1'b0;
    bus.d_stb   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_sel   = 4'hf;
    bus.d_adr   = '0;
    bus.d_dat_w = '0;
    bus.s_dat_r = '0;
    bus.s_ack   = 1'b0;
  endtask

  task automatic req_d(input logic [31:0] adr);
    bus.d_cyc = 1'b1;
    bus.d_stb = 1'b1;
    bus.d_adr = adr;
  endtask

  task automatic req_i(input logic [31:0] adr);
    bus.i_cyc = 1'b1;
    bus.i_stb = 1'b1;
    bus.i_adr = adr;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    settle();
    chk("rst_scyc", {31'd0, bus.s_cyc}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    tick();
    settle();
    chk("rst_sadr", bus.s_adr, 32'd0);
    chk("rst_acks", {28'd0, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 32'd0);
    rst = 1'b0;
    tick();
    settle();
    chk("post_rst_grant", {30'd0, grant}, 32'd0);
    chk("post_rst_scyc", {31'd0, bus.s_cyc}, 32'd0);

    // Single data read at 0x100, ack on third granted cycle
    req_d(32'h100);
    settle();
    chk("t1_idle_scyc", {31'd0, bus.s_cyc}, 32'd0);
    tick();
    settle();
    chk("t1_lat_scyc", {31'd0, bus.s_cyc}, 32'd1);
    chk("t1_grant", {30'd0, grant}, 32'd2);
    chk("t1_sadr", bus.s_adr, 32'h100);
    tick();
    settle();
    chk("t1_wait_dack", {31'd0, bus.d_ack}, 32'd0);
    tick();
    bus.s_ack   = 1'b1;
    bus.s_dat_r = 32'hDEADBEEF;
    settle();
    chk("t1_dack", {31'd0, bus.d_ack}, 32'd1);
    chk("t1_ddat", bus.d_dat_r, 32'hDEADBEEF);
    chk("t1_iack", {31'd0, bus.i_ack}, 32'd0);
    chk("t1_idat", bus.i_dat_r, 32'd0);
    tick();
    drive_idle();
    settle();
    chk("t1_after_grant", {30'd0, grant}, 32'd0);
    chk("t1_after_scyc", {31'd0, bus.s_cyc}, 32'd0);

    // Round robin from reset: data, idle, instr, idle, data
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_d(32'h0000_1000);
    req_i(32'h0000_2000);
    settle();
    chk("t2_c0_grant", {30'd0, grant}, 32'd0);
    tick();
    bus.s_ack   = 1'b1;
    bus.s_dat_r = 32'h1111_1111;
    settle();
    chk("t2_c1_grant", {30'd0, grant}, 32'd2);
    chk("t2_c1_dack", {31'd0, bus.d_ack}, 32'd1);
    chk("t2_c1_iack", {31'd0, bus.i_ack}, 32'd0);
    tick();
    bus.s_ack = 1'b0;
    settle();
    chk("t2_c2_grant", {30'd0, grant}, 32'd0);
    tick();
    bus.s_ack   = 1'b1;
    bus.s_dat_r = 32'h2222_2222;
    settle();
    chk("t2_c3_grant", {30'd0, grant}, 32'd1);
    chk("t2_c3_iack", {31'd0, bus.i_ack}, 32'd1);
    chk("t2_c3_idat", bus.i_dat_r, 32'h2222_2222);
    chk("t2_c3_dack", {31'd0, bus.d_ack}, 32'd0);
    chk("t2_c3_sadr", bus.s_adr, 32'h0000_2000);
    tick();
    bus.s_ack = 1'b0;
    settle();
    chk("t2_c4_grant", {30'd0, grant}, 32'd0);
    tick();
    bus.s_ack = 1'b1;
    settle();
    chk("t2_c5_grant", {30'd0, grant}, 32'd2);
    chk("t2_c5_sadr", bus.s_adr, 32'h0000_1000);

    // Instr fetch while data master presents we=1, sel=0011
    tick();
    bus.s_ack = 1'b0;
    bus.d_cyc = 1'b0;
    bus.d_stb = 1'b0;
    bus.d_we  = 1'b1;
    bus.d_sel = 4'b0011;
    req_i(32'h200);
    settle();
    chk("t3_c6_grant", {30'd0, grant}, 32'd0);
    tick();
    settle();
    chk("t3_c7_grant", {30'd0, grant}, 32'd1);
    chk("t3_c7_swe", {31'd0, bus.s_we}, 32'd0);
    chk("t3_c7_ssel", {28'd0, bus.s_sel}, 32'hf);
    chk("t3_c7_sadr", bus.s_adr, 32'h200);
    bus.d_cyc = 1'b1;
    bus.d_stb = 1'b1;
    bus.d_adr = 32'h400;
    tick();
    settle();
    chk("t3_c8_swe", {31'd0, bus.s_we}, 32'd0);
    chk("t3_c8_ssel", {28'd0, bus.s_sel}, 32'hf);
    chk("t3_c8_dack", {31'd0, bus.d_ack}, 32'd0);
    tick();
    bus.s_ack = 1'b1;
    settle();
    chk("t3_c9_iack", {31'd0, bus.i_ack}, 32'd1);
    chk("t3_c9_ssel", {28'd0, bus.s_sel}, 32'hf);
    bus.i_cyc = 1'b0;
    bus.i_stb = 1'b0;
    tick();
    bus.s_ack = 1'b0;
    settle();
    chk("t3_c10_grant", {30'd0, grant}, 32'd0);
    tick();
    bus.s_ack = 1'b1;
    settle();
    chk("t3_c11_grant", {30'd0, grant}, 32'd2);
    chk("t3_c11_swe", {31'd0, bus.s_we}, 32'd1);
    chk("t3_c11_ssel", {28'd0, bus.s_sel}, 32'h3);
    chk("t3_c11_dack", {31'd0, bus.d_ack}, 32'd1);
    tick();
    drive_idle();

    // Slave never acks: d_err on the 16th granted cycle
    req_d(32'h300);
    tick();
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      settle();
      chk($sformatf("t4_k%0d_derr", k), {31'd0, bus.d_err}, 32'd0);
      if (k == 1) req_i(32'h500);
      tick();
    end
    settle();
    chk("t4_k15_derr", {31'd0, bus.d_err}, 32'd1);
    chk("t4_k15_scyc", {31'd0, bus.s_cyc}, 32'd1);
    chk("t4_k15_ierr", {31'd0, bus.i_err}, 32'd0);
    tick();
    bus.d_cyc = 1'b0;
    bus.d_stb = 1'b0;
    settle();
    chk("t4_post_scyc", {31'd0, bus.s_cyc}, 32'd0);
    chk("t4_post_derr", {31'd0, bus.d_err}, 32'd0);
    chk("t4_post_grant", {30'd0, grant}, 32'd0);
    tick();
    bus.s_ack = 1'b1;
    settle();
    chk("t4_igrant", {30'd0, grant}, 32'd1);
    chk("t4_isadr", bus.s_adr, 32'h500);
    chk("t4_iack", {31'd0, bus.i_ack}, 32'd1);
    tick();
    drive_idle();

    // Reset asserted two cycles into GNT_D
    req_d(32'h600);
    tick();
    settle();
    chk("t5_g0_grant", {30'd0, grant}, 32'd2);
    tick();
    rst       = 1'b1;
    bus.s_ack = 1'b1;
    settle();
    chk("t5_rst_dack", {31'd0, bus.d_ack}, 32'd0);
    chk("t5_rst_derr", {31'd0, bus.d_err}, 32'd0);
    tick();
    rst       = 1'b0;
    bus.s_ack = 1'b0;
    settle();
    chk("t5_post_scyc", {31'd0, bus.s_cyc}, 32'd0);
    chk("t5_post_grant", {30'd0, grant}, 32'd0);
    chk("t5_post_acks", {28'd0, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 32'd0);
    bus.d_cyc = 1'b0;
    bus.d_stb = 1'b0;
    tick();

    // Data master aborts, then a tie goes to instr
    req_d(32'h700);
    tick();
    settle();
    chk("t6_g0_grant", {30'd0, grant}, 32'd2);
    tick();
    bus.d_cyc = 1'b0;
    bus.d_stb = 1'b0;
    settle();
    chk("t6_abort_scyc", {31'd0, bus.s_cyc}, 32'd0);
    chk("t6_abort_dack", {31'd0, bus.d_ack}, 32'd0);
    tick();
    settle();
    chk("t6_idle_grant", {30'd0, grant}, 32'd0);
    chk("t6_idle_acks", {28'd0, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 32'd0);
    req_d(32'h800);
    req_i(32'h900);
    tick();
    bus.s_ack = 1'b1;
    settle();
    chk("t6_tie_grant", {30'd0, grant}, 32'd1);
    chk("t6_tie_iack", {31'd0, bus.i_ack}, 32'd1);
    chk("t6_tie_dack", {31'd0, bus.d_ack}, 32'd0);
    tick();
    drive_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
